tt_lock_detect: RTL and testbench
=================================

// Module: tt_lock_detect
// PURPOSE
//  Lock detector with hysteresis for the DPLL feedback loop. Consumes PFD up/down pulses and the
//  divided feedback clock. Declares lock after LOCK_CNT consecutive clean feedback periods and
//  drops lock after UNLOCK_CNT consecutive erroneous periods.
//  Replaces the single-cycle up/down decode at the top level. Sits in the scan chain after divide-by-N.
// PARAMETERS
//  LOCK_CNT    16  consecutive clean feedback periods needed to assert lock (>=2)
//  UNLOCK_CNT  4   consecutive erroneous feedback periods needed to drop lock (>=2)
//  CNT_W       8   period counter width; must hold max(LOCK_CNT,UNLOCK_CNT)-1
// PORTS
//  i_clk_gen    in   1  generated (fast) clock; sole clock of this block
//  i_rst_n      in   1  asynchronous active-low reset
//  i_up         in   1  PFD up pulse (i_clk_gen domain)
//  i_down       in   1  PFD down pulse (i_clk_gen domain)
//  i_clk_div    in   1  divided feedback clock, sampled as data on i_clk_gen
//  i_clear      in   1  clears sticky o_lock_lost
//  o_locked     out  1  lock indicator
//  o_lock_lost  out  1  sticky: lock dropped since last reset/clear
//  o_state      out  2  FSM state, for debug
//  i_scan_en    in   1  scan shift enable
//  i_scan_in    in   1  scan data in
//  o_scan_out   out  1  scan data out
// BEHAVIOUR
//  Clock/reset: one clock, i_clk_gen. Asynchronous active-low reset i_rst_n. All flops reset to 0.
//    Outputs at reset: o_locked=0, o_lock_lost=0, o_state=0.
//  Period boundary: div_q <= i_clk_div every functional cycle. bnd = i_clk_div & ~div_q.
//  err_flag: set in any cycle with i_up|i_down.
//    At bnd: err = err_flag|i_up|i_down, and err_flag loads 0. A pulse in the boundary cycle counts
//    toward the ending period.
//  FSM (state changes only on bnd; encoding: UNLOCKED=0, ACQUIRE=1, LOCKED=2, SLIP=3):
//    UNLOCKED: clean -> ACQUIRE, good=1; err -> stay, good=0
//    ACQUIRE : clean and good==LOCK_CNT-1 -> LOCKED, good=0; clean otherwise -> good++;
//              err -> UNLOCKED, good=0
//    LOCKED  : clean -> stay, bad=0; err -> SLIP, bad=1
//    SLIP    : err and bad==UNLOCK_CNT-1 -> UNLOCKED, bad=0, lost=1; err otherwise -> bad++;
//              clean -> LOCKED, bad=0
//  Outputs:
//    o_locked = (state==LOCKED)|(state==SLIP). It is decoded from the state flops, with no extra
//      delay, and rises in the cycle after the LOCK_CNT-th clean bnd.
//    o_lock_lost = lost. lost clears when i_clear=1. If set and clear occur in the same cycle, set wins.
//    o_state = state.
//  Counters never wrap; the FSM resets them before their limits.
//  Scan: while i_scan_en=1, every flop shifts and all functional updates (including i_clear) are
//    suppressed. Chain order:
//    i_scan_in->div_q->err_flag->state[0]->state[1]->good[0..CNT_W-1]->bad[0..CNT_W-1]->lost->o_scan_out
//    Chain length = 5+2*CNT_W (21 at default).
//  Reset asserted mid-operation returns to UNLOCKED at once. o_locked drops asynchronously.
// TESTING
//  T1 Defaults, i_clk_div=clk/10, up=down=0 -> o_locked rises 1 cycle after 16th rising edge of
//     i_clk_div; o_state path 0->1->2.
//  T2 Lock, then a single up pulse in one period -> SLIP (o_state=3), o_locked stays 1; next clean
//     period -> LOCKED; o_lock_lost=0.
//  T3 Lock, then down pulse every period -> o_locked=0 after 4th erroneous bnd; o_lock_lost=1 until
//     i_clear; clear and a new set in the same cycle -> stays 1.
//  T4 In ACQUIRE with good=10, up pulse exactly on bnd cycle -> UNLOCKED, good=0; relock takes 16
//     more clean periods.
//  T5 Scan: shift 21 bits of pattern 101100... with i_scan_en=1 -> same pattern appears on
//     o_scan_out 21 cycles later; state unchanged by i_up/i_clear during shift.
//  T6 Assert i_rst_n=0 while locked, between clock edges -> o_locked=0 immediately; all flops 0.

Source files
------------

// File: rtl/tt_lock_detect.sv
// DPLL lock detector with hysteresis: counts clean/erroneous feedback periods. Latency: state moves on the edge that samples a period boundary.
// No backpressure; up/down pulses are consumed every cycle, and i_scan_en freezes all functional updates.
module tt_lock_detect #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic       i_clk_gen,
    input  logic       i_rst_n,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_clk_div,
    input  logic       i_clear,
    output logic       o_locked,
    output logic       o_lock_lost,
    output logic [1:0] o_state,
    input  logic       i_scan_en,
    input  logic       i_scan_in,
    output logic       o_scan_out
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        SLIP     = 2'd3
    } state_t;

    localparam int               CHAIN_W   = 5 + 2 * CNT_W;
    localparam logic [CNT_W-1:0] GOOD_LAST = CNT_W'(LOCK_CNT - 1);
    localparam logic [CNT_W-1:0] BAD_LAST  = CNT_W'(UNLOCK_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         state_raw;
    logic               div_q;
    logic               err_flag;
    logic               err_flag_nxt;
    logic               lost;
    logic               lost_nxt;
    logic               lost_set;
    logic [CNT_W-1:0]   good;
    logic [CNT_W-1:0]   good_nxt;
    logic [CNT_W-1:0]   bad;
    logic [CNT_W-1:0]   bad_nxt;
    logic               bnd;
    logic               err;
    logic [CHAIN_W-1:0] chain_shift;

    assign state_raw = state;

    // Rising edge of the divided clock marks the end of one feedback period.
    assign bnd = i_clk_div & ~div_q;
    // A pulse in the boundary cycle still belongs to the period that is ending.
    assign err = err_flag | i_up | i_down;

    assign err_flag_nxt = bnd ? 1'b0 : err;
    assign lost_nxt     = lost_set | (lost & ~i_clear);

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        bad_nxt   = bad;
        lost_set  = 1'b0;
        if (bnd) begin
            case (state)
                UNLOCKED: begin
                    if (err) begin
                        good_nxt = '0;
                    end else begin
                        state_nxt = ACQUIRE;
                        good_nxt  = CNT_ONE;
                    end
                end
                ACQUIRE: begin
                    if (err) begin
                        state_nxt = UNLOCKED;
                        good_nxt  = '0;
                    end else if (good == GOOD_LAST) begin
                        state_nxt = LOCKED;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good + CNT_ONE;
                    end
                end
                LOCKED: begin
                    if (err) begin
                        state_nxt = SLIP;
                        bad_nxt   = CNT_ONE;
                    end else begin
                        bad_nxt = '0;
                    end
                end
                SLIP: begin
                    if (!err) begin
                        state_nxt = LOCKED;
                        bad_nxt   = '0;
                    end else if (bad == BAD_LAST) begin
                        state_nxt = UNLOCKED;
                        bad_nxt   = '0;
                        lost_set  = 1'b1;
                    end else begin
                        bad_nxt = bad + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = UNLOCKED;
                end
            endcase
        end
    end

    // Chain image after one shift: bit 0 is the new div_q, top bit is the new lost.
    assign chain_shift = {bad, good, state_raw, err_flag, div_q, i_scan_in};

    always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q    <= 1'b0;
            err_flag <= 1'b0;
            state    <= UNLOCKED;
            good     <= '0;
            bad      <= '0;
            lost     <= 1'b0;
        end else if (i_scan_en) begin
            div_q    <= chain_shift[0];
            err_flag <= chain_shift[1];
            state    <= state_t'(chain_shift[3:2]);
            good     <= chain_shift[4 +: CNT_W];
            bad      <= chain_shift[4 + CNT_W +: CNT_W];
            lost     <= chain_shift[CHAIN_W-1];
        end else begin
            div_q    <= i_clk_div;
            err_flag <= err_flag_nxt;
            state    <= state_nxt;
            good     <= good_nxt;
            bad      <= bad_nxt;
            lost     <= lost_nxt;
        end
    end

    assign o_locked    = state_raw[1];
    assign o_state     = state_raw;
    assign o_lock_lost = lost;
    assign o_scan_out  = lost;

endmodule

// File: tb/tb_tt_lock_detect.sv
// Bench for tt_lock_detect: directed lock/slip/unlock/scan/reset steps plus randomized periods
// compared against a period-level lock model.
module tb_tt_lock_detect;

    localparam int LOCK_CNT   = 16;
    localparam int UNLOCK_CNT = 4;
    localparam int CNT_W      = 8;
    localparam int CHAIN_W    = 5 + 2 * CNT_W;

    logic       i_clk_gen;
    logic       i_rst_n;
    logic       i_up;
    logic       i_down;
    logic       i_clk_div;
    logic       i_clear;
    logic       o_locked;
    logic       o_lock_lost;
    logic [1:0] o_state;
    logic       i_scan_en;
    logic       i_scan_in;
    logic       o_scan_out;

    int checks = 0;
    int errors = 0;

    // Period-level model: locked flag plus length of the current run of periods
    // that argue against the present lock status (clean runs when unlocked,
    // erroneous runs when locked).
    bit m_locked;
    bit m_dirty;
    bit m_prev_div;
    bit m_lost;
    int m_run;

    tt_lock_detect #(
        .LOCK_CNT  (LOCK_CNT),
        .UNLOCK_CNT(UNLOCK_CNT),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk_gen  (i_clk_gen),
        .i_rst_n    (i_rst_n),
        .i_up       (i_up),
        .i_down     (i_down),
        .i_clk_div  (i_clk_div),
        .i_clear    (i_clear),
        .o_locked   (o_locked),
        .o_lock_lost(o_lock_lost),
        .o_state    (o_state),
        .i_scan_en  (i_scan_en),
        .i_scan_in  (i_scan_in),
        .o_scan_out (o_scan_out)
    );

    initial i_clk_gen = 1'b0;
    always #5 i_clk_gen = ~i_clk_gen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_state();
        if (m_locked) return (m_run != 0) ? 3 : 2;
        return (m_run != 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_locked   = 1'b0;
        m_dirty    = 1'b0;
        m_prev_div = 1'b0;
        m_lost     = 1'b0;
        m_run      = 0;
    endtask

    // One functional clock: drive, update the model at the edge, compare 1 time unit later.
    task automatic tick(input logic div, input logic up, input logic dn, input logic clr,
                        input string tag);
        bit is_bnd;
        bit is_err;
        bit set_lost;
        i_clk_div = div;
        i_up      = up;
        i_down    = dn;
        i_clear   = clr;
        @(posedge i_clk_gen);
        is_bnd     = div && !m_prev_div;
        m_prev_div = div;
        set_lost   = 1'b0;
        if (is_bnd) begin
            is_err  = m_dirty || up || dn;
            m_dirty = 1'b0;
            if (!m_locked) begin
                m_run = is_err ? 0 : m_run + 1;
                if (m_run == LOCK_CNT) begin
                    m_locked = 1'b1;
                    m_run    = 0;
                end
            end else begin
                m_run = is_err ? m_run + 1 : 0;
                if (m_run == UNLOCK_CNT) begin
                    m_locked = 1'b0;
                    m_run    = 0;
                    set_lost = 1'b1;
                end
            end
        end else begin
            m_dirty = m_dirty || up || dn;
        end
        if (set_lost) m_lost = 1'b1;
        else if (clr) m_lost = 1'b0;
        #1;
        check({tag, "_state"}, int'(o_state), model_state());
        check({tag, "_locked"}, int'(o_locked), int'(m_locked));
        check({tag, "_lost"}, int'(o_lock_lost), int'(m_lost));
    endtask

    // One feedback period of len cycles; cycle 0 is the boundary cycle. -1 means no event.
    task automatic period(input int len, input int up_at, input int dn_at, input int clr_at,
                          input string tag);
        for (int c = 0; c < len; c++)
            tick(c < len / 2, c == up_at, c == dn_at, c == clr_at, tag);
    endtask

    initial begin
        int rate;
        int len;
        int up_at;
        int dn_at;
        int clr_at;
        logic [CHAIN_W-1:0] pat;

        i_rst_n   = 1'b0;
        i_up      = 1'b0;
        i_down    = 1'b0;
        i_clk_div = 1'b0;
        i_clear   = 1'b0;
        i_scan_en = 1'b0;
        i_scan_in = 1'b0;
        model_reset();
        for (int k = 0; k < CHAIN_W; k++) pat[k] = (k % 6 == 0) || (k % 6 == 2) || (k % 6 == 3);

        #12;
        check("rst_locked", int'(o_locked), 0);
        check("rst_lost", int'(o_lock_lost), 0);
        check("rst_state", int'(o_state), 0);
        check("rst_scan_out", int'(o_scan_out), 0);
        @(negedge i_clk_gen);
        i_rst_n = 1'b1;

        // T1: plain acquisition at clk/10
        period(10, -1, -1, -1, "t1");
        check("t1_acquire", int'(o_state), 1);
        for (int p = 2; p <= LOCK_CNT - 1; p++) period(10, -1, -1, -1, "t1");
        check("t1_not_yet", int'(o_locked), 0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, "t1_bnd16");
        check("t1_locked", int'(o_locked), 1);
        check("t1_state_locked", int'(o_state), 2);
        for (int c = 1; c < 10; c++) tick(c < 5, 1'b0, 1'b0, 1'b0, "t1");

        // T2: single up pulse -> SLIP, then back to LOCKED
        period(10, 3, -1, -1, "t2");
        period(10, -1, -1, -1, "t2");
        check("t2_slip", int'(o_state), 3);
        check("t2_slip_locked", int'(o_locked), 1);
        period(10, -1, -1, -1, "t2");
        check("t2_relocked", int'(o_state), 2);
        check("t2_lost", int'(o_lock_lost), 0);

        // T3: down pulse every period -> unlock, sticky lost, clear, set-wins
        for (int p = 0; p < UNLOCK_CNT; p++) period(10, -1, 2, -1, "t3");
        period(10, -1, -1, -1, "t3");
        check("t3_unlocked", int'(o_locked), 0);
        check("t3_lost_set", int'(o_lock_lost), 1);
        period(10, -1, -1, 5, "t3_clr");
        check("t3_lost_cleared", int'(o_lock_lost), 0);
        for (int p = 0; p < LOCK_CNT; p++) period(10, -1, -1, -1, "t3_relock");
        check("t3_relocked", int'(o_locked), 1);
        for (int p = 0; p < UNLOCK_CNT; p++) period(10, -1, 2, -1, "t3");
        period(10, -1, -1, 0, "t3_setclr");
        check("t3_set_wins", int'(o_lock_lost), 1);

        // T4: ACQUIRE with good=10, up pulse in the boundary cycle
        for (int p = 0; p < 10; p++) period(10, -1, -1, -1, "t4");
        check("t4_acquire", int'(o_state), 1);
        period(10, 0, -1, -1, "t4_hit");
        check("t4_dropped", int'(o_state), 0);
        for (int p = 0; p < LOCK_CNT - 1; p++) period(10, -1, -1, -1, "t4");
        check("t4_still_acq", int'(o_state), 1);
        period(10, -1, -1, -1, "t4");
        check("t4_relocked", int'(o_locked), 1);

        // Randomized periods with a varying error rate per segment
        for (int p = 0; p < 400; p++) begin
            if (p % 50 == 0) rate = $urandom_range(2, 24);
            len    = $urandom_range(4, 14);
            up_at  = ($urandom_range(0, rate - 1) == 0) ? $urandom_range(0, len - 1) : -1;
            dn_at  = ($urandom_range(0, rate - 1) == 0) ? $urandom_range(0, len - 1) : -1;
            clr_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
            period(len, up_at, dn_at, clr_at, "rnd");
        end

        // T6: asynchronous reset while locked
        for (int p = 0; p < LOCK_CNT; p++) period(8, -1, -1, -1, "t6_lock");
        check("t6_pre_locked", int'(o_locked), 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("t6_locked_drop", int'(o_locked), 0);
        check("t6_state", int'(o_state), 0);
        check("t6_lost", int'(o_lock_lost), 0);
        model_reset();
        @(posedge i_clk_gen);
        #1;
        check("t6_held_state", int'(o_state), 0);
        @(negedge i_clk_gen);
        i_rst_n   = 1'b1;
        i_scan_en = 1'b1;
        i_scan_in = 1'b0;
        for (int k = 0; k < CHAIN_W; k++) begin
            @(posedge i_clk_gen);
            #1;
            check("t6_flops_zero", int'(o_scan_out), 0);
        end

        // T5: shift a pattern through the chain while functional inputs are active
        for (int k = 0; k < 2 * CHAIN_W - 1; k++) begin
            i_scan_in = (k < CHAIN_W) ? pat[k] : 1'b0;
            i_up      = 1'b1;
            i_clear   = 1'b1;
            i_clk_div = k[0];
            @(posedge i_clk_gen);
            #1;
            if (k == CHAIN_W - 1)
                check("t5_state_bits", int'(o_state), int'({pat[CHAIN_W - 4], pat[CHAIN_W - 3]}));
            if (k >= CHAIN_W - 1)
                check("t5_scan_out", int'(o_scan_out), int'(pat[k - (CHAIN_W - 1)]));
        end
        i_scan_en = 1'b0;
        i_up      = 1'b0;
        i_clear   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
